// File: rtl/isp_ccm.sv
// 3x3 colour correction matrix on an RGB888 stream, with frame-synchronous coefficient updates.
// Optional macro ISP_CCM_OFFSET_EN adds per-channel signed offsets at staging addresses 9..11.
`timescale 1ns/1ps
module isp_ccm #(
    parameter int ROW_WIDTH = 1936,
    parameter int COL_WIDTH = 1088,
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  per_img_clken,
    input  logic [3*DATA_W-1:0]   per_img_data,
    input  logic                  coef_wr_en,
    input  logic [3:0]            coef_wr_addr,
    input  logic [COEF_W-1:0]     coef_wr_data,
    input  logic                  coef_commit,
    output logic                  coef_pending,
    output logic                  frame_done,
    output logic                  post_img_clken,
    output logic [3*DATA_W-1:0]   post_img_data
);
    localparam int FRAME_LEN = ROW_WIDTH * COL_WIDTH;
    localparam int CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int PROD_W    = DATA_W + 1 + COEF_W;
    localparam int SUM_W     = PROD_W + 2;
    localparam int FRAC      = 8;
    localparam int RND_W     = SUM_W + 1;
    localparam int CLP_W     = RND_W - FRAC;
    localparam logic [CNT_W-1:0]         LAST_PIX = CNT_W'(FRAME_LEN - 1);
    localparam logic signed [COEF_W-1:0] UNITY    = COEF_W'(256);

    logic signed [COEF_W-1:0] r_stg [9];
    logic signed [COEF_W-1:0] r_act [9];
    logic [CNT_W-1:0]         r_pix_cnt;
    logic                     r_pending;
    logic                     r_frame_done;
    logic                     r_vld_p1, r_vld_p2, r_vld_p3;
    logic [3*DATA_W-1:0]      r_data_p3;
    logic signed [PROD_W-1:0] r_prod_p1 [9];
    logic signed [SUM_W-1:0]  r_sum_p2 [3];
    logic signed [DATA_W:0]   w_pix_s [3];
    logic [DATA_W-1:0]        w_out [3];
    logic                     w_apply;
    logic                     w_last;
`ifdef ISP_CCM_OFFSET_EN
    logic signed [8:0]        r_stg_off [3];
    logic signed [8:0]        r_act_off [3];
    logic signed [8:0]        r_off_p1 [3];
    logic signed [8:0]        r_off_p2 [3];
`endif

    function automatic logic signed [CLP_W-1:0] round_q8(input logic signed [SUM_W-1:0] s);
        logic signed [RND_W-1:0] t;
        t = RND_W'(s) + RND_W'(128);
        return CLP_W'(t >>> FRAC);
    endfunction

    function automatic logic [DATA_W-1:0] clamp_u8(input logic signed [CLP_W-1:0] v);
        if (v < 0)
            return '0;
        else if (v > 255)
            return '1;
        else
            return v[DATA_W-1:0];
    endfunction

    // An apply only happens in an idle slot at the frame boundary, never alongside a pixel.
    assign w_apply = r_pending && (r_pix_cnt == '0) && !per_img_clken;
    assign w_last  = per_img_clken && (r_pix_cnt == LAST_PIX);

    always_comb begin
        for (int c = 0; c < 3; c++)
            w_pix_s[c] = {1'b0, per_img_data[(2-c)*DATA_W +: DATA_W]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                r_stg[i] <= (i % 4 == 0) ? UNITY : '0;
                r_act[i] <= (i % 4 == 0) ? UNITY : '0;
            end
`ifdef ISP_CCM_OFFSET_EN
            for (int i = 0; i < 3; i++) begin
                r_stg_off[i] <= '0;
                r_act_off[i] <= '0;
            end
`endif
            r_pix_cnt    <= '0;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
            r_vld_p1     <= 1'b0;
            r_vld_p2     <= 1'b0;
            r_vld_p3     <= 1'b0;
            r_data_p3    <= '0;
        end else begin
            for (int i = 0; i < 9; i++)
                if (coef_wr_en && coef_wr_addr == 4'(i))
                    r_stg[i] <= coef_wr_data;
`ifdef ISP_CCM_OFFSET_EN
            for (int i = 0; i < 3; i++)
                if (coef_wr_en && coef_wr_addr == 4'(9 + i))
                    r_stg_off[i] <= coef_wr_data[8:0];
            if (w_apply)
                r_act_off <= r_stg_off;
`endif
            if (w_apply)
                r_act <= r_stg;
            r_pending <= coef_commit | (r_pending & ~w_apply);
            if (per_img_clken)
                r_pix_cnt <= w_last ? '0 : r_pix_cnt + 1'b1;
            r_frame_done <= w_last;
            r_vld_p1     <= per_img_clken;
            r_vld_p2     <= r_vld_p1;
            r_vld_p3     <= r_vld_p2;
            if (r_vld_p2)
                r_data_p3 <= {w_out[0], w_out[1], w_out[2]};
        end
    end

    // S1: products against the bank active at pixel entry
    always_ff @(posedge clk) begin
        if (per_img_clken) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    r_prod_p1[3*r+c] <= PROD_W'(w_pix_s[c]) * PROD_W'(r_act[3*r+c]);
`ifdef ISP_CCM_OFFSET_EN
            r_off_p1 <= r_act_off;
`endif
        end
    end

    // S2: per-channel row sums
    always_ff @(posedge clk) begin
        if (r_vld_p1) begin
            for (int r = 0; r < 3; r++)
                r_sum_p2[r] <= SUM_W'(r_prod_p1[3*r]) + SUM_W'(r_prod_p1[3*r+1])
                             + SUM_W'(r_prod_p1[3*r+2]);
`ifdef ISP_CCM_OFFSET_EN
            r_off_p2 <= r_off_p1;
`endif
        end
    end

    // S3: round, offset, clamp (registered in the control block above)
    always_comb begin
        for (int r = 0; r < 3; r++) begin
`ifdef ISP_CCM_OFFSET_EN
            w_out[r] = clamp_u8(round_q8(r_sum_p2[r]) + CLP_W'(r_off_p2[r]));
`else
            w_out[r] = clamp_u8(round_q8(r_sum_p2[r]));
`endif
        end
    end

    assign coef_pending   = r_pending;
    assign frame_done     = r_frame_done;
    assign post_img_clken = r_vld_p3;
    assign post_img_data  = r_data_p3;

endmodule

// File: tb/tb_isp_ccm.sv
// Directed scoreboard bench for isp_ccm on a 4x2 frame: expected pixels are queued
// at issue with their due cycle, and a monitor pops them as output strobes appear.
`timescale 1ns/1ps
module tb_isp_ccm;
    logic        clk;
    logic        rst_n;
    logic        per_img_clken;
    logic [23:0] per_img_data;
    logic        coef_wr_en;
    logic [3:0]  coef_wr_addr;
    logic [11:0] coef_wr_data;
    logic        coef_commit;
    logic        coef_pending;
    logic        frame_done;
    logic        post_img_clken;
    logic [23:0] post_img_data;

    typedef struct {
        logic [23:0] data;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   fd_cnt = 0;
    int   pcnt = 0;
    int   fd0;

    isp_ccm #(.ROW_WIDTH(4), .COL_WIDTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .per_img_clken (per_img_clken),
        .per_img_data  (per_img_data),
        .coef_wr_en    (coef_wr_en),
        .coef_wr_addr  (coef_wr_addr),
        .coef_wr_data  (coef_wr_data),
        .coef_commit   (coef_commit),
        .coef_pending  (coef_pending),
        .frame_done    (frame_done),
        .post_img_clken(post_img_clken),
        .post_img_data (post_img_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (frame_done === 1'b1)
            fd_cnt <= fd_cnt + 1;
    end

    always @(negedge clk) begin
        if (post_img_clken !== 1'b0) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_strobe: got data %06h at cycle %0d, required no strobe",
                         post_img_data, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                if (post_img_data !== mon_e.data || cyc != mon_e.cyc) begin
                    n_bad++;
                    $display("FAIL pixel: got %06h at cycle %0d, required %06h at cycle %0d",
                             post_img_data, cyc, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic drive(input logic ck, input logic [23:0] d, input logic [23:0] e,
                         input logic we, input logic [3:0] a, input logic [11:0] wd,
                         input logic cm);
        @(negedge clk);
        per_img_clken = ck;
        per_img_data  = d;
        coef_wr_en    = we;
        coef_wr_addr  = a;
        coef_wr_data  = wd;
        coef_commit   = cm;
        if (ck) begin
            sb_q.push_back('{e, cyc + 3});
            pcnt = (pcnt + 1) % 8;
        end
    endtask

    task automatic px(input logic [23:0] d, input logic [23:0] e);
        drive(1'b1, d, e, 1'b0, 4'd0, 12'd0, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 24'd0, 24'd0, 1'b0, 4'd0, 12'd0, 1'b0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [11:0] wd);
        drive(1'b0, 24'd0, 24'd0, 1'b1, a, wd, 1'b0);
    endtask

    task automatic commit();
        drive(1'b0, 24'd0, 24'd0, 1'b0, 4'd0, 12'd0, 1'b1);
    endtask

    task automatic fill();
        while (pcnt != 0)
            px(24'h000000, 24'h000000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        per_img_clken = 1'b0;
        per_img_data  = '0;
        coef_wr_en    = 1'b0;
        coef_wr_addr  = '0;
        coef_wr_data  = '0;
        coef_commit   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_clken", 32'(post_img_clken), 32'd0);
        chk("rst_data", 32'(post_img_data), 32'd0);
        chk("rst_pending", 32'(coef_pending), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;

        // Identity bank, one full frame
        px(24'h804020, 24'h804020);
        px(24'h000000, 24'h000000);
        px(24'hFFFFFF, 24'hFFFFFF);
        px(24'h123456, 24'h123456);
        px(24'h010203, 24'h010203);
        px(24'hA5A5A5, 24'hA5A5A5);
        px(24'h7F8081, 24'h7F8081);
        px(24'h00FF00, 24'h00FF00);
        idle();
        chk("fd_frame1", 32'(frame_done), 32'd1);
        idle();
        chk("fd_clear", 32'(frame_done), 32'd0);
        chk("pending_idle", 32'(coef_pending), 32'd0);

        // Saturation high: c00 = 2.0
        wr(4'd0, 12'd512);
        commit();
        idle();
        chk("pending_set", 32'(coef_pending), 32'd1);
        idle();
        chk("pending_applied", 32'(coef_pending), 32'd0);
        px(24'hC80000, 24'hFF0000);
        // Staging mid-frame must not reach the active bank
        wr(4'd0, 12'd256);
        wr(4'd1, 12'hF00);
        commit();
        px(24'h0A3200, 24'h143200);
        chk("pending_midframe", 32'(coef_pending), 32'd1);
        fill();
        idle();
        px(24'h0A3200, 24'h003200);
        chk("pending_cleared2", 32'(coef_pending), 32'd0);
        px(24'h640A00, 24'h5A0A00);

        // Rounding: c00 = 1.5
        wr(4'd0, 12'd384);
        wr(4'd1, 12'd0);
        commit();
        fill();
        idle();
        px(24'h030000, 24'h050000);
        px(24'h010000, 24'h020000);
        px(24'hFF0000, 24'hFF0000);
        px(24'h020507, 24'h030507);

        // Back to identity
        wr(4'd0, 12'd256);
        commit();
        fill();
        idle();

        // Frame-sync update: commit at pixel 3 with c00 = 0
        px(24'h101010, 24'h101010);
        fd0 = fd_cnt;
        px(24'h101010, 24'h101010);
        px(24'h101010, 24'h101010);
        drive(1'b1, 24'h404040, 24'h404040, 1'b1, 4'd0, 12'd0, 1'b1);
        px(24'h404040, 24'h404040);
        chk("sync_pending_p4", 32'(coef_pending), 32'd1);
        px(24'h404040, 24'h404040);
        px(24'h404040, 24'h404040);
        px(24'h404040, 24'h404040);
        chk("sync_pending_p7", 32'(coef_pending), 32'd1);
        idle();
        chk("sync_fd", 32'(frame_done), 32'd1);
        chk("sync_pending_boundary", 32'(coef_pending), 32'd1);
        px(24'h404040, 24'h004040);
        chk("sync_pending_clear", 32'(coef_pending), 32'd0);
        chk("sync_fd_once", 32'(fd_cnt - fd0), 32'd1);

        // Two back-to-back frames; the apply at the mid boundary must wait
        fill();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, {8'(i * 10 + 5), 8'(i), 8'h55}, {8'h00, 8'(i), 8'h55},
                  (i == 0), 4'd0, 12'd256, (i == 0));
            if (i == 1)
                fd0 = fd_cnt;
            if (i == 9)
                chk("burst_pending_deferred", 32'(coef_pending), 32'd1);
        end
        idle();
        chk("burst_pending_end", 32'(coef_pending), 32'd1);
        px(24'h0A0B0C, 24'h0A0B0C);
        chk("burst_applied", 32'(coef_pending), 32'd0);
        chk("burst_fd_count", 32'(fd_cnt - fd0), 32'd2);

        // Reset mid-frame with three pixels in flight and a commit pending
        wr(4'd0, 12'd0);
        commit();
        idle();
        chk("pre_reset_pending", 32'(coef_pending), 32'd1);
        @(negedge clk);
        per_img_clken = 1'b1;
        per_img_data  = 24'h111111;
        @(negedge clk);
        per_img_data  = 24'h222222;
        @(negedge clk);
        per_img_data  = 24'h333333;
        #2;
        rst_n = 1'b0;
        per_img_clken = 1'b0;
        pcnt = 0;
        @(negedge clk);
        chk("mid_rst_clken", 32'(post_img_clken), 32'd0);
        chk("mid_rst_data", 32'(post_img_data), 32'd0);
        chk("mid_rst_pending", 32'(coef_pending), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        idle();
        idle();
        commit();
        idle();
        px(24'h112233, 24'h112233);
        chk("post_rst_pending", 32'(coef_pending), 32'd0);
        for (int i = 1; i < 8; i++)
            px(24'h112233, 24'h112233);
        idle();
        chk("post_rst_fd", 32'(frame_done), 32'd1);
        repeat (5) idle();
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
